// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types, widths and tick derivation for key_debounce
package key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_fsm_e;

    localparam int DCNT_W = 8;
    localparam int HCNT_W = 16;

    // Clock cycles per 1 ms tick.
    function automatic int tick_div(input int clk_hz);
        return clk_hz / 1000;
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: 2-flop synchronizer plus debounce FSM
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   tick          shared 1 ms strobe, one cycle wide
//   key_n         raw active-low pin, asynchronous to clk
//   key_state     debounced level, 1 = pressed
//   key_press     one-cycle pulse on accepted press
//   key_release   one-cycle pulse on accepted release
//   key_long      one-cycle pulse once hold reaches LONG_MS
module key_debounce_ch
    import key_pkg::*;
#(
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic key_n,
    output logic key_state,
    output logic key_press,
    output logic key_release,
    output logic key_long
);

    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_MS - 1);
    localparam logic [HCNT_W-1:0] HCNT_LIM  = HCNT_W'(LONG_MS);
    localparam logic [HCNT_W-1:0] HCNT_PRE  = HCNT_W'(LONG_MS - 1);

    // Flops reset to 1 so the key reads as released until the pin is seen.
    logic [1:0] sync;
    logic       k;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    assign k = ~sync[1];

    key_fsm_e          state, state_nxt;
    logic [DCNT_W-1:0] dcnt, dcnt_nxt;
    logic [HCNT_W-1:0] hcnt, hcnt_nxt;
    logic              level_nxt, press_nxt, release_nxt, long_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            dcnt        <= '0;
            hcnt        <= '0;
            key_state   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
            key_long    <= 1'b0;
        end else begin
            state       <= state_nxt;
            dcnt        <= dcnt_nxt;
            hcnt        <= hcnt_nxt;
            key_state   <= level_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            key_long    <= long_nxt;
        end
    end

    // A change of k always takes priority over a coincident tick, so a
    // bounce landing on the tick restarts the wait instead of completing it.
    always_comb begin
        state_nxt   = state;
        dcnt_nxt    = dcnt;
        hcnt_nxt    = hcnt;
        level_nxt   = key_state;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        long_nxt    = 1'b0;
        case (state)
            IDLE: begin
                if (k) begin
                    state_nxt = PRESS_WAIT;
                    dcnt_nxt  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!k) begin
                    state_nxt = IDLE;
                end else if (tick) begin
                    if (dcnt == DCNT_LAST) begin
                        state_nxt = HELD;
                        level_nxt = 1'b1;
                        press_nxt = 1'b1;
                        hcnt_nxt  = '0;
                    end else begin
                        dcnt_nxt = dcnt + DCNT_W'(1);
                    end
                end
            end
            HELD: begin
                if (!k) begin
                    state_nxt = RELEASE_WAIT;
                    dcnt_nxt  = '0;
                end else if (tick && (hcnt < HCNT_LIM)) begin
                    // Saturates at HCNT_LIM, so the long pulse fires once per hold.
                    hcnt_nxt = hcnt + HCNT_W'(1);
                    long_nxt = (hcnt == HCNT_PRE);
                end
            end
            RELEASE_WAIT: begin
                if (k) begin
                    // Glitch inside a hold: resume without disturbing hcnt.
                    state_nxt = HELD;
                end else if (tick) begin
                    if (dcnt == DCNT_LAST) begin
                        state_nxt   = IDLE;
                        level_nxt   = 1'b0;
                        release_nxt = 1'b1;
                    end else begin
                        dcnt_nxt = dcnt + DCNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - debounced push-button inputs with press/release/long-press pulses
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset
//   key_n         raw active-low button pins [NKEYS]
//   key_state     debounced levels, 1 = pressed [NKEYS]
//   key_press     one-cycle accepted-press pulses [NKEYS]
//   key_release   one-cycle accepted-release pulses [NKEYS]
//   key_long      one-cycle long-press pulses [NKEYS]
module key_debounce
    import key_pkg::*;
#(
    parameter int NKEYS       = 4,
    parameter int CLK_HZ      = 50_000_000,
    parameter int DEBOUNCE_MS = 20,
    parameter int LONG_MS     = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NKEYS-1:0] key_n,
    output logic [NKEYS-1:0] key_state,
    output logic [NKEYS-1:0] key_press,
    output logic [NKEYS-1:0] key_release,
    output logic [NKEYS-1:0] key_long
);

    localparam int TICK_DIV = tick_div(CLK_HZ);
    localparam int PW       = $clog2(TICK_DIV);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    for (genvar i = 0; i < NKEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_MS (DEBOUNCE_MS),
            .LONG_MS     (LONG_MS)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .tick        (tick),
            .key_n       (key_n[i]),
            .key_state   (key_state[i]),
            .key_press   (key_press[i]),
            .key_release (key_release[i]),
            .key_long    (key_long[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - self-checking bench for key_debounce
module tb_key_debounce;

    localparam int NK = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_state, key_press, key_release, key_long;

    key_debounce #(
        .NKEYS       (NK),
        .CLK_HZ      (10_000),
        .DEBOUNCE_MS (3),
        .LONG_MS     (10)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .key_n       (key_n),
        .key_state   (key_state),
        .key_press   (key_press),
        .key_release (key_release),
        .key_long    (key_long)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc_no = 0;
    int tick_cnt = 0;
    int press_cnt[NK];
    int rel_cnt[NK];
    int long_cnt[NK];

    typedef struct {
        logic [NK-1:0] key_n;
        int            cycles;
        logic [NK-1:0] exp_state;
        int            exp_press;
        int            exp_release;
        int            exp_long;
    } vec_t;

    vec_t vecs[5];

    task automatic step();
        @(posedge clk);
        #1;
        cyc_no++;
        tick_cnt += int'(dut.tick);
        for (int i = 0; i < NK; i++) begin
            press_cnt[i] += int'(key_press[i]);
            rel_cnt[i]   += int'(key_release[i]);
            long_cnt[i]  += int'(key_long[i]);
        end
    endtask

    task automatic clear_counts();
        tick_cnt = 0;
        for (int i = 0; i < NK; i++) begin
            press_cnt[i] = 0;
            rel_cnt[i]   = 0;
            long_cnt[i]  = 0;
        end
    endtask

    function automatic int sum(input int a[NK]);
        int s = 0;
        for (int i = 0; i < NK; i++) s += a[i];
        return s;
    endfunction

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d", name, act, lo, hi);
        end
    endtask

    int t0, tp, tl, bad;

    initial begin
        // key_n, cycles, exp_state, press, release, long (sums over all keys)
        vecs[0] = '{4'hF, 200, 4'b0000, 0, 0, 0};
        vecs[1] = '{4'hE,  50, 4'b0001, 1, 0, 0};
        vecs[2] = '{4'hF,  50, 4'b0000, 0, 1, 0};
        vecs[3] = '{4'hA, 150, 4'b0101, 2, 0, 2};
        vecs[4] = '{4'hF,  50, 4'b0000, 0, 2, 0};

        rst   = 1'b1;
        key_n = 4'hF;
        clear_counts();
        for (int c = 0; c < 5; c++) step();
        check_int("reset_outputs", int'({key_state, key_press, key_release, key_long}), 0);
        rst = 1'b0;

        for (int v = 0; v < 5; v++) begin
            clear_counts();
            key_n = vecs[v].key_n;
            for (int c = 0; c < vecs[v].cycles; c++) step();
            check_int($sformatf("vec%0d_state", v), int'(key_state), int'(vecs[v].exp_state));
            check_int($sformatf("vec%0d_press", v), sum(press_cnt), vecs[v].exp_press);
            check_int($sformatf("vec%0d_release", v), sum(rel_cnt), vecs[v].exp_release);
            check_int($sformatf("vec%0d_long", v), sum(long_cnt), vecs[v].exp_long);
            if (v == 0) check_int("tick_per_200", tick_cnt, 20);
        end

        // Press latency and pulse width on key 0.
        clear_counts();
        key_n[0] = 1'b0;
        t0 = cyc_no;
        for (int c = 0; c < 60; c++) begin
            step();
            if (key_press[0]) break;
        end
        check_range("press_latency", cyc_no - t0, 23, 33);
        check_int("press_state", int'(key_state[0]), 1);
        step();
        check_int("press_width", int'(key_press[0]), 0);
        for (int c = 0; c < 20; c++) step();
        check_int("press_once", press_cnt[0], 1);
        key_n[0] = 1'b1;
        t0 = cyc_no;
        for (int c = 0; c < 60; c++) begin
            step();
            if (key_release[0]) break;
        end
        check_range("release_latency", cyc_no - t0, 23, 33);
        check_int("release_state", int'(key_state[0]), 0);
        step();
        check_int("release_width", int'(key_release[0]), 0);

        // Key 1 bouncing every 7 cycles is never accepted.
        clear_counts();
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            if (c % 7 == 0) key_n[1] = ~key_n[1];
            step();
            if (key_state[1]) bad++;
        end
        key_n[1] = 1'b1;
        for (int c = 0; c < 40; c++) begin
            step();
            if (key_state[1]) bad++;
        end
        check_int("bounce_state", bad, 0);
        check_int("bounce_press", press_cnt[1], 0);
        check_int("bounce_release", rel_cnt[1], 0);

        // Key 2 long press fires exactly once.
        clear_counts();
        key_n[2] = 1'b0;
        tp = -1000;
        tl = -1000;
        for (int c = 0; c < 60; c++) begin
            step();
            if (key_press[2]) begin tp = cyc_no; break; end
        end
        for (int c = 0; c < 150; c++) begin
            step();
            if (key_long[2]) begin tl = cyc_no; break; end
        end
        check_range("long_delay", tl - tp, 90, 110);
        for (int c = 0; c < 150; c++) step();
        check_int("long_once", long_cnt[2], 1);
        key_n[2] = 1'b1;
        for (int c = 0; c < 50; c++) step();
        check_int("long_release", rel_cnt[2], 1);

        // Key 3: a 5-cycle glitch inside HELD neither releases nor disturbs the hold.
        clear_counts();
        key_n[3] = 1'b0;
        tp = -1000;
        tl = -1000;
        bad = 0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (key_press[3]) begin tp = cyc_no; break; end
        end
        for (int c = 0; c < 30; c++) begin
            step();
            if (!key_state[3]) bad++;
        end
        key_n[3] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            if (!key_state[3]) bad++;
        end
        key_n[3] = 1'b0;
        for (int c = 0; c < 150; c++) begin
            step();
            if (!key_state[3]) bad++;
            if (key_long[3]) begin tl = cyc_no; break; end
        end
        check_int("glitch_state", bad, 0);
        check_int("glitch_release", rel_cnt[3], 0);
        check_range("glitch_long_delay", tl - tp, 90, 110);
        key_n[3] = 1'b1;
        for (int c = 0; c < 50; c++) step();

        // Reset in the middle of PRESS_WAIT on all keys.
        clear_counts();
        key_n = 4'h0;
        for (int c = 0; c < 15; c++) step();
        check_int("prewait_state", int'(key_state), 0);
        rst = 1'b1;
        #1;
        bad = int'({key_state, key_press, key_release, key_long} != '0);
        for (int c = 0; c < 5; c++) begin
            step();
            if ({key_state, key_press, key_release, key_long} != '0) bad++;
        end
        check_int("midreset_outputs", bad, 0);
        rst = 1'b0;
        for (int c = 0; c < 60; c++) begin
            step();
            if (key_press != '0) break;
        end
        check_int("postreset_press_all", int'(key_press), 4'hF);
        check_int("postreset_state", int'(key_state), 4'hF);
        check_int("postreset_no_release", sum(rel_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
